// File: rtl/sevseg_pkg.sv
// Shared seven-segment constants, digit enables and capture state encoding.
// Segment patterns are active-low, bit 6 = a ... bit 0 = g, matching the display driver.
package sevseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIG_S1    = 4'b1110;
  localparam logic [3:0] DIG_S10   = 4'b1101;
  localparam logic [3:0] DIG_M1    = 4'b1011;
  localparam logic [3:0] DIG_M10   = 4'b0111;
  localparam logic [3:0] DIG_BLANK = 4'b1111;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    GOT_S1  = 2'd1,
    GOT_S10 = 2'd2,
    GOT_M1  = 2'd3
  } cap_state_e;

  typedef struct packed {
    logic [3:0] digit;
    logic [6:0] seg;
  } samp_t;

  function automatic logic is_one_hot_low(input logic [3:0] d);
    return (d == DIG_S1) || (d == DIG_S10) || (d == DIG_M1) || (d == DIG_M10);
  endfunction

  // Digit enable that legally advances the frame from each state.
  function automatic logic [3:0] expected_digit(input cap_state_e st);
    logic [3:0] d;
    case (st)
      HUNT:    d = DIG_S1;
      GOT_S1:  d = DIG_S10;
      GOT_S10: d = DIG_M1;
      default: d = DIG_M10;
    endcase
    return d;
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    return ({3'b000, tens} * 7'd10) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/sevseg_capture_if.sv
// Display-side bus of the capture block: raw segment/digit lines in, decoded frame out.
// master = display/stimulus side, slave = capture block.
interface sevseg_capture_if;
  logic [6:0] seg;
  logic [3:0] digit;
  logic [6:0] min_out;
  logic [6:0] sec_out;
  logic       frame_valid;
  logic       err_seg;
  logic       err_order;

  modport master (
    output seg, digit,
    input  min_out, sec_out, frame_valid, err_seg, err_order
  );

  modport slave (
    input  seg, digit,
    output min_out, sec_out, frame_valid, err_seg, err_order
  );
endinterface

// File: rtl/sevseg_decode.sv
// Combinational seven-segment to BCD decode; vld is low for any non-digit pattern.
// Zero latency, no backpressure.
module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] val,
  output logic       vld
);

  always_comb begin
    val = 4'd0;
    vld = 1'b1;
    case (seg)
      SEG_0:   val = 4'd0;
      SEG_1:   val = 4'd1;
      SEG_2:   val = 4'd2;
      SEG_3:   val = 4'd3;
      SEG_4:   val = 4'd4;
      SEG_5:   val = 4'd5;
      SEG_6:   val = 4'd6;
      SEG_7:   val = 4'd7;
      SEG_8:   val = 4'd8;
      SEG_9:   val = 4'd9;
      default: vld = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevseg_capture.sv
// Captures a multiplexed 4-digit display back into binary min/sec; frame_valid STABLE_CYCLES+1
// edges after min tens appears (+2 with SEVSEG_CAP_SYNC_EN input synchronizer); no backpressure.
module sevseg_capture
  import sevseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic             clk,
  input  logic             rst,
  sevseg_capture_if.slave  bus
);

  localparam int               SW       = $clog2(STABLE_CYCLES);
  localparam int               TW       = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]    STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]    TMO_MAX  = TW'(TIMEOUT);
  localparam samp_t            SAMP_BLANK = '{digit: DIG_BLANK, seg: SEG_BLANK};

  samp_t         samp_d, samp_q;
  logic [SW-1:0] stab_cnt_d, stab_cnt_q;
  logic          accepted_d, accepted_q;
  logic          accept;
  logic [3:0]    dec_val;
  logic          dec_vld;

  cap_state_e    state_d, state_q;
  logic [TW-1:0] tmo_d, tmo_q;
  logic [3:0]    s1_d, s1_q, s10_d, s10_q, m1_d, m1_q;
  logic [6:0]    min_d, min_q, sec_d, sec_q;
  logic          frame_valid_d, frame_valid_q;
  logic          err_seg_d, err_seg_q;
  logic          err_order_d, err_order_q;

`ifdef SEVSEG_CAP_SYNC_EN
  samp_t sync1_d, sync1_q, sync2_q;

  always_comb begin
    sync1_d = '{digit: bus.digit, seg: bus.seg};
    samp_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= SAMP_BLANK;
      sync2_q <= SAMP_BLANK;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync1_q;
    end
  end
`else
  always_comb begin
    samp_d = '{digit: bus.digit, seg: bus.seg};
  end
`endif

  sevseg_decode u_decode (
    .seg (samp_q.seg),
    .val (dec_val),
    .vld (dec_vld)
  );

  // Acceptance fires once per dwell; accepted_q holds it off until samp moves.
  assign accept = is_one_hot_low(samp_q.digit) && (stab_cnt_q == STAB_MAX) && !accepted_q;

  always_comb begin
    stab_cnt_d = stab_cnt_q;
    accepted_d = accepted_q;
    if ((samp_d != samp_q) || !is_one_hot_low(samp_d.digit)) begin
      stab_cnt_d = '0;
      accepted_d = 1'b0;
    end else begin
      if (stab_cnt_q != STAB_MAX) begin
        stab_cnt_d = stab_cnt_q + SW'(1);
      end
      if (accept) begin
        accepted_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    tmo_d         = '0;
    s1_d          = s1_q;
    s10_d         = s10_q;
    m1_d          = m1_q;
    min_d         = min_q;
    sec_d         = sec_q;
    frame_valid_d = 1'b0;
    err_seg_d     = 1'b0;
    err_order_d   = 1'b0;

    if (accept) begin
      if (!dec_vld) begin
        err_seg_d = 1'b1;
        state_d   = HUNT;
      end else if (samp_q.digit == expected_digit(state_q)) begin
        case (state_q)
          HUNT: begin
            s1_d    = dec_val;
            state_d = GOT_S1;
          end
          GOT_S1: begin
            s10_d   = dec_val;
            state_d = GOT_S10;
          end
          GOT_S10: begin
            m1_d    = dec_val;
            state_d = GOT_M1;
          end
          default: begin
            min_d         = bcd_to_bin(dec_val, m1_q);
            sec_d         = bcd_to_bin(s10_q, s1_q);
            frame_valid_d = 1'b1;
            state_d       = HUNT;
          end
        endcase
      end else if (state_q != HUNT) begin
        // Out-of-order digit; a fresh sec-ones digit restarts the frame immediately.
        err_order_d = 1'b1;
        if (samp_q.digit == DIG_S1) begin
          s1_d    = dec_val;
          state_d = GOT_S1;
        end else begin
          state_d = HUNT;
        end
      end
    end else if (state_q != HUNT) begin
      tmo_d = tmo_q + TW'(1);
      if (tmo_d == TMO_MAX) begin
        tmo_d   = '0;
        state_d = HUNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q        <= SAMP_BLANK;
      stab_cnt_q    <= '0;
      accepted_q    <= 1'b0;
      state_q       <= HUNT;
      tmo_q         <= '0;
      s1_q          <= '0;
      s10_q         <= '0;
      m1_q          <= '0;
      min_q         <= '0;
      sec_q         <= '0;
      frame_valid_q <= 1'b0;
      err_seg_q     <= 1'b0;
      err_order_q   <= 1'b0;
    end else begin
      samp_q        <= samp_d;
      stab_cnt_q    <= stab_cnt_d;
      accepted_q    <= accepted_d;
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      s1_q          <= s1_d;
      s10_q         <= s10_d;
      m1_q          <= m1_d;
      min_q         <= min_d;
      sec_q         <= sec_d;
      frame_valid_q <= frame_valid_d;
      err_seg_q     <= err_seg_d;
      err_order_q   <= err_order_d;
    end
  end

  assign bus.min_out     = min_q;
  assign bus.sec_out     = sec_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.err_seg     = err_seg_q;
  assign bus.err_order   = err_order_q;

endmodule

// File: doc/sevseg_capture.md
Name: sevseg_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment display driver.
- Watches the active-low segment bus and the active-low one-hot digit enables, filters out switching glitches, and decodes each digit pattern back to BCD.
- Assembles the four digits of one refresh frame and publishes binary minutes and seconds with a one-cycle valid strobe.
- Used in loopback self-check on the board and as a bench monitor for the display path.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required to accept a digit. Must be at least 2 and less than the driver dwell of 11 cycles.
- TIMEOUT, 64: cycles without an accepted digit before a partial frame is discarded.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- seg  input  7  segment cathodes, active-low. Bit 6 is segment a, bit 0 is segment g.
- digit  input  4  digit anodes, active-low one-hot. 1110 = sec ones, 1101 = sec tens, 1011 = min ones, 0111 = min tens.
- min_out  output  7  captured minutes, 0..99.
- sec_out  output  7  captured seconds, 0..99.
- frame_valid  output  1  one-cycle pulse when min_out/sec_out update.
- err_seg  output  1  one-cycle pulse when a stable but undecodable pattern is seen.
- err_order  output  1  one-cycle pulse when a stable digit arrives out of sequence.

Behaviour:
- Reset, or rst sampled high on any edge: all outputs are 0, state is HUNT, and the stability counter, timeout counter and digit registers are cleared. rst overrides every other event.
- Input stage: {digit, seg} is registered once into samp.
- Stability filter:
  - stab_cnt clears whenever samp differs from its previous value; otherwise it saturates upward.
  - A digit is accepted once per dwell, on the cycle stab_cnt reaches STABLE_CYCLES-1.
  - An `accepted` flag blocks re-acceptance until samp changes.
- Non-one-hot digit values (blank 1111, or multiple enables) reset stability. They are never accepted and never raise an error.
- Decode table (seg to value): 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9. Any other pattern is invalid.
- State machine states: HUNT, GOT_S1, GOT_S10, GOT_M1.
  - HUNT: accept of 1110 with a valid pattern stores sec ones and moves to GOT_S1. Accepts of any other digit are ignored silently.
  - GOT_S1: expects 1101. GOT_S10: expects 1011. GOT_M1: expects 0111.
  - Expected digit with a valid pattern: store it and advance.
  - Accept of 0111 in GOT_M1: compute min_out = tens*10+ones and sec_out = tens*10+ones, registered. frame_valid pulses in the cycle after the accept edge. Return to HUNT.
  - Unexpected digit in a non-HUNT state: err_order pulses and the frame is discarded. If that digit is 1110 with a valid pattern, it starts a new frame (go to GOT_S1); otherwise go to HUNT.
  - Invalid pattern on any accepted one-hot digit: err_seg pulses, go to HUNT. If both error conditions apply, only err_seg pulses.
- Timeout:
  - The timeout counter runs outside HUNT and clears on every accept.
  - When it reaches TIMEOUT, return to HUNT with no error pulse and no output update.
  - An accept in the same cycle wins over the timeout.
- Latency: with the value at the ports from edge k, it is in samp at k+1 and accepted at edge k+STABLE_CYCLES. frame_valid is high for one cycle, starting STABLE_CYCLES+1 edges after min tens appears.
- min_out/sec_out hold their last published values between frames, through errors and timeouts.
- Arithmetic: the BCD-to-binary multiply-by-10 plus add is done at 7 bits. No overflow is possible for values up to 99.

Optional Feature:
- Macro SEVSEG_CAP_SYNC_EN.
- When defined: a 2-flop synchronizer is inserted ahead of samp for off-board or asynchronous capture. All latencies grow by exactly 2 cycles, and synchronizer flops reset to blank (digit=1111, seg=1111111).
- When undefined: direct single register, as described in Behaviour.

Decomposition:
- Package sevseg_pkg holds:
  - the ten segment pattern constants (shared with the display driver);
  - the four digit-enable constants;
  - the state encoding.
- Sub-module sevseg_decode is a purely combinational mapping of seg to a 4-bit value plus a valid flag.

Test Plan:
- Loopback with the display driver at min=12, sec=34, 11-cycle dwell → frame_valid once per 44-cycle frame, min_out=12, sec_out=34, no errors.
- Change seg for 2 cycles mid-dwell on digit 1101, with STABLE_CYCLES=4 → glitch not accepted; the frame still yields 12/34.
- Hold seg=1111111 stable on digit 1101 after a valid 1110 → err_seg single pulse; no frame_valid until the next complete frame; outputs unchanged.
- Drive 1110 (5) then 1011 (3) → err_order pulse, state HUNT. Then a full sequence 0,0,0,1 (sec ones, sec tens, min ones, min tens) → min_out=10, sec_out=0.
- Drive 1110 and 1101, then blank for TIMEOUT+1 cycles → no pulses. A subsequent full 5,9,9,5 sequence → min_out=59, sec_out=95.
- Assert rst after three accepted digits → all outputs 0 on the next edge. A single min tens digit after release produces no frame_valid.
